// File: rtl/sys_defs.sv
// Shared system definitions for the processor/memory interface.
//   XLEN          : processor address width
//   BUS_COMMAND   : command encoding on the proc2mem channel
//   MEM_SIZE      : access size encoding
//   MEM_OWNER     : which cache owns an outstanding load
//   MEM_TAG_ENTRY : one slot of the outstanding-load tag table
package sys_defs;

  localparam int XLEN          = 32;
  localparam int MEM_TAG_W     = 4;   // memory tags 1..15, 0 means "none"
  localparam int MEM_TAG_COUNT = 15;
  localparam int MEM_ID_W      = 3;   // client request id width held in the tag table

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic                valid;
    MEM_OWNER            owner;
    logic [MEM_ID_W-1:0] id;
  } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load table indexed by memory tag (1..15).
//   clock, reset : clock and synchronous active-high reset (empties the table)
//   wr_en/wr_tag/wr_entry : allocate port, written at the clock edge
//   rd_tag       : combinational lookup of the returning tag (0 reads as empty)
//   rd_clear     : invalidate the rd_tag entry at the clock edge
//   rd_entry     : entry currently stored at rd_tag
// When the same tag is allocated and cleared in one cycle the allocate wins,
// because the returning load and the new load share the tag.
module mem_tag_table
  import sys_defs::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [MEM_TAG_W-1:0] wr_tag,
  input  MEM_TAG_ENTRY         wr_entry,
  input  logic [MEM_TAG_W-1:0] rd_tag,
  input  logic                 rd_clear,
  output MEM_TAG_ENTRY         rd_entry
);

  MEM_TAG_ENTRY entries [1:MEM_TAG_COUNT];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_entry = '0;
    if (rd_tag != '0) rd_entry = entries[rd_tag];
  end

  // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: this storage is reset on purpose; stale valid bits would claim pre-reset tags.
      for (int i = 1; i <= MEM_TAG_COUNT; i++) entries[i] <= '0;
    end else begin
      for (int i = 1; i <= MEM_TAG_COUNT; i++) begin
        if (wr_en && wr_tag == MEM_TAG_W'(i))
          entries[i] <= wr_entry;
        else if (rd_clear && rd_tag == MEM_TAG_W'(i))
          entries[i].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Processor-side initiator for the unified memory bus.
// Arbitrates icache and dcache requests onto proc2mem_*, remembers each accepted
// load by its memory tag, and steers returning data to the owning cache.
//   clock, reset          : clock and synchronous active-high reset
//   ic_req_*              : icache load request (always a DOUBLE load)
//   dc_req_*              : dcache load/store request
//   *_req_accept          : the memory took that client's request this cycle
//   ic_rsp_valid/dc_rsp_valid, rsp_data, rsp_id : returned load data
//   stray_tag             : a returned tag had no outstanding entry
//   proc2mem_*            : bus command channel to memory
//   mem2proc_response     : 0 refused, else tag given to the accepted request
//   mem2proc_data/tag     : load return channel (tag 0 = nothing returning)
// ID_W must equal sys_defs::MEM_ID_W, which sizes the stored id.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int ID_W         = MEM_ID_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 ic_req_valid,
  input  logic [XLEN-1:0]      ic_req_addr,
  input  logic [ID_W-1:0]      ic_req_id,
  output logic                 ic_req_accept,

  input  logic                 dc_req_valid,
  input  BUS_COMMAND           dc_req_cmd,
  input  logic [XLEN-1:0]      dc_req_addr,
  input  logic [63:0]          dc_req_data,
  input  MEM_SIZE              dc_req_size,
  input  logic [ID_W-1:0]      dc_req_id,
  output logic                 dc_req_accept,

  output logic                 ic_rsp_valid,
  output logic                 dc_rsp_valid,
  output logic [63:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 stray_tag,

  output BUS_COMMAND           proc2mem_command,
  output logic [XLEN-1:0]      proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  output MEM_SIZE              proc2mem_size,

  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;
  logic                ic_wins;
  logic                dc_wins;
  logic                mem_accepts;
  logic                alloc_en;
  logic                ret_hit;
  MEM_TAG_ENTRY        alloc_entry;
  MEM_TAG_ENTRY        ret_entry;

  // dcache normally has priority; a starved icache takes one turn.
  assign ic_wins     = ic_req_valid &&
                       (!dc_req_valid || starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign dc_wins     = dc_req_valid && !ic_wins;
  assign mem_accepts = (mem2proc_response != '0);

  assign ic_req_accept = ic_wins && mem_accepts;
  assign dc_req_accept = dc_wins && mem_accepts;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = BYTE;
    if (ic_wins) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = ic_req_addr;
      proc2mem_size    = DOUBLE;
    end else if (dc_wins) begin
      proc2mem_command = dc_req_cmd;
      proc2mem_addr    = dc_req_addr;
      proc2mem_data    = dc_req_data;
      proc2mem_size    = dc_req_size;
    end
  end

  // Only loads get a table entry; stores return nothing.
  always_comb begin
    alloc_en          = ic_req_accept || (dc_req_accept && dc_req_cmd == BUS_LOAD);
    alloc_entry       = '0;
    alloc_entry.valid = 1'b1;
    alloc_entry.owner = ic_wins ? OWNER_ICACHE : OWNER_DCACHE;
    alloc_entry.id    = ic_wins ? MEM_ID_W'(ic_req_id) : MEM_ID_W'(dc_req_id);
  end

  mem_tag_table u_tag_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (alloc_en),
    .wr_tag   (mem2proc_response),
    .wr_entry (alloc_entry),
    .rd_tag   (mem2proc_tag),
    .rd_clear (ret_hit),
    .rd_entry (ret_entry)
  );

  // Returns are routed in the same cycle they appear on the bus.
  assign ret_hit      = (mem2proc_tag != '0) && ret_entry.valid;
  assign ic_rsp_valid = ret_hit && (ret_entry.owner == OWNER_ICACHE);
  assign dc_rsp_valid = ret_hit && (ret_entry.owner == OWNER_DCACHE);
  assign rsp_data     = ret_hit ? mem2proc_data : '0;
  assign rsp_id       = ret_hit ? ID_W'(ret_entry.id) : '0;
  assign stray_tag    = (mem2proc_tag != '0) && !ret_entry.valid;

  // Counts consecutive cycles a waiting icache request went unserved.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (ic_req_valid && !ic_req_accept) begin
      if (starve_cnt != STARVE_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the bus.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  localparam int ID_W         = 3;
  localparam int STARVE_LIMIT = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             ic_req_valid;
  logic [XLEN-1:0]  ic_req_addr;
  logic [ID_W-1:0]  ic_req_id;
  logic             ic_req_accept;
  logic             dc_req_valid;
  BUS_COMMAND       dc_req_cmd;
  logic [XLEN-1:0]  dc_req_addr;
  logic [63:0]      dc_req_data;
  MEM_SIZE          dc_req_size;
  logic [ID_W-1:0]  dc_req_id;
  logic             dc_req_accept;
  logic             ic_rsp_valid;
  logic             dc_rsp_valid;
  logic [63:0]      rsp_data;
  logic [ID_W-1:0]  rsp_id;
  logic             stray_tag;
  BUS_COMMAND       proc2mem_command;
  logic [XLEN-1:0]  proc2mem_addr;
  logic [63:0]      proc2mem_data;
  MEM_SIZE          proc2mem_size;
  logic [3:0]       mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [3:0]       mem2proc_tag;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.ID_W(ID_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock             (clock),
    .reset             (reset),
    .ic_req_valid      (ic_req_valid),
    .ic_req_addr       (ic_req_addr),
    .ic_req_id         (ic_req_id),
    .ic_req_accept     (ic_req_accept),
    .dc_req_valid      (dc_req_valid),
    .dc_req_cmd        (dc_req_cmd),
    .dc_req_addr       (dc_req_addr),
    .dc_req_data       (dc_req_data),
    .dc_req_size       (dc_req_size),
    .dc_req_id         (dc_req_id),
    .dc_req_accept     (dc_req_accept),
    .ic_rsp_valid      (ic_rsp_valid),
    .dc_rsp_valid      (dc_rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_id            (rsp_id),
    .stray_tag         (stray_tag),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_size     (proc2mem_size),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who holds each tag, and how long icache has waited.
  bit m_valid [16];
  bit m_owner [16];   // 0 = icache, 1 = dcache
  int m_id    [16];
  int m_starve;
  bit last_ic_acc;
  bit last_dc_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ic_req_valid      = 1'b0;
    ic_req_addr       = '0;
    ic_req_id         = '0;
    dc_req_valid      = 1'b0;
    dc_req_cmd        = BUS_NONE;
    dc_req_addr       = '0;
    dc_req_data       = '0;
    dc_req_size       = BYTE;
    dc_req_id         = '0;
    mem2proc_response = '0;
    mem2proc_data     = '0;
    mem2proc_tag      = '0;
  endtask

  // Called shortly after a falling edge with inputs already driven: checks every
  // output against the model, then advances the model across the rising edge.
  task automatic step();
    bit icw, dcw, acc, hit, is_load, icv, rst;
    logic [63:0] e_cmd, e_addr, e_data, e_size;
    int t, r, ic_id, dc_id;
    #2;
    rst   = reset;
    icv   = ic_req_valid;
    ic_id = int'(ic_req_id);
    dc_id = int'(dc_req_id);
    t     = int'(mem2proc_tag);
    r     = int'(mem2proc_response);
    acc   = (r != 0);
    icw   = icv && (!dc_req_valid || m_starve >= STARVE_LIMIT);
    dcw   = dc_req_valid && !icw;
    e_cmd = 0; e_addr = 0; e_data = 0; e_size = 0;
    if (icw) begin
      e_cmd = 64'(BUS_LOAD); e_addr = 64'(ic_req_addr); e_size = 64'(DOUBLE);
    end else if (dcw) begin
      e_cmd = 64'(dc_req_cmd); e_addr = 64'(dc_req_addr);
      e_data = dc_req_data; e_size = 64'(dc_req_size);
    end
    hit = (t != 0) && m_valid[t];
    check("ic_req_accept", 64'(ic_req_accept), 64'(icw && acc));
    check("dc_req_accept", 64'(dc_req_accept), 64'(dcw && acc));
    check("proc2mem_command", 64'(proc2mem_command), e_cmd);
    check("proc2mem_addr", 64'(proc2mem_addr), e_addr);
    check("proc2mem_data", proc2mem_data, e_data);
    check("proc2mem_size", 64'(proc2mem_size), e_size);
    check("ic_rsp_valid", 64'(ic_rsp_valid), 64'(hit && !m_owner[t]));
    check("dc_rsp_valid", 64'(dc_rsp_valid), 64'(hit && m_owner[t]));
    check("rsp_data", rsp_data, hit ? mem2proc_data : 64'h0);
    check("rsp_id", 64'(rsp_id), hit ? 64'(m_id[t]) : 64'h0);
    check("stray_tag", 64'(stray_tag), 64'((t != 0) && !m_valid[t]));
    last_ic_acc = icw && acc;
    last_dc_acc = dcw && acc;
    is_load = last_ic_acc || (last_dc_acc && dc_req_cmd == BUS_LOAD);
    @(posedge clock);
    if (rst) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      m_starve = 0;
    end else begin
      if (hit) m_valid[t] = 1'b0;
      if (is_load) begin
        m_valid[r] = 1'b1;
        m_owner[r] = !icw;
        m_id[r]    = icw ? ic_id : dc_id;
      end
      if (icv && !last_ic_acc) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
      else                     m_starve = 0;
    end
    @(negedge clock);
  endtask

  initial begin
    int free_q[$];
    int out_q[$];
    bit ic_pend, dc_pend;
    int rt;

    for (int k = 0; k < 16; k++) begin m_valid[k] = 0; m_owner[k] = 0; m_id[k] = 0; end
    m_starve = 0;
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    step();
    step();
    reset = 1'b0;
    step();

    // Single icache load, tag 3, data returns two cycles later.
    ic_req_valid = 1'b1; ic_req_addr = 32'h100; ic_req_id = 3'd5; mem2proc_response = 4'd3;
    #1 check("t1_ic_accept", 64'(ic_req_accept), 64'd1);
    step();
    idle_inputs();
    step();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF;
    #1 check("t1_ic_rsp_valid", 64'(ic_rsp_valid), 64'd1);
    check("t1_rsp_data", rsp_data, 64'hDEAD_BEEF);
    check("t1_rsp_id", 64'(rsp_id), 64'd5);
    step();
    idle_inputs();

    // Both valid: dcache store wins, no entry created for tag 5.
    ic_req_valid = 1'b1; ic_req_addr = 32'h180; ic_req_id = 3'd1;
    dc_req_valid = 1'b1; dc_req_cmd = BUS_STORE; dc_req_addr = 32'h200;
    dc_req_data = 64'h1234_5678_9ABC_DEF0; dc_req_size = WORD; dc_req_id = 3'd2;
    mem2proc_response = 4'd5;
    #1 check("t2_dc_accept", 64'(dc_req_accept), 64'd1);
    check("t2_ic_accept", 64'(ic_req_accept), 64'd0);
    check("t2_cmd_store", 64'(proc2mem_command), 64'(BUS_STORE));
    step();
    idle_inputs();
    mem2proc_tag = 4'd5; mem2proc_data = 64'h55;
    #1 check("t2_store_stray", 64'(stray_tag), 64'd1);
    step();
    idle_inputs();

    // Starvation: icache loses 8 cycles, wins the 9th, then starts over.
    for (int i = 0; i < 10; i++) begin
      ic_req_valid = 1'b1; ic_req_addr = 32'h400 + 32'(i * 8); ic_req_id = ID_W'(i);
      dc_req_valid = 1'b1; dc_req_cmd = BUS_STORE; dc_req_addr = 32'h800 + 32'(i * 8);
      dc_req_data = 64'(i); dc_req_size = DOUBLE; dc_req_id = 3'd7;
      mem2proc_response = 4'(i + 1);
      #1 check("t3_starve_ic_accept", 64'(ic_req_accept), 64'(i == 8));
      step();
    end
    idle_inputs();

    // Refused three times, then accepted with tag 7; request stays on the bus.
    for (int i = 0; i < 4; i++) begin
      dc_req_valid = 1'b1; dc_req_cmd = BUS_LOAD; dc_req_addr = 32'h300;
      dc_req_size = WORD; dc_req_id = 3'd2;
      mem2proc_response = (i == 3) ? 4'd7 : 4'd0;
      #1 check("t4_dc_accept", 64'(dc_req_accept), 64'(i == 3));
      check("t4_addr_stable", 64'(proc2mem_addr), 64'h300);
      step();
    end
    idle_inputs();

    // Tag 4 returns and is reallocated in the same cycle.
    ic_req_valid = 1'b1; ic_req_addr = 32'h500; ic_req_id = 3'd1; mem2proc_response = 4'd4;
    step();
    idle_inputs();
    dc_req_valid = 1'b1; dc_req_cmd = BUS_LOAD; dc_req_addr = 32'h600;
    dc_req_size = DOUBLE; dc_req_id = 3'd6; mem2proc_response = 4'd4;
    mem2proc_tag = 4'd4; mem2proc_data = 64'hAAAA;
    #1 check("t5_old_owner_ic", 64'(ic_rsp_valid), 64'd1);
    check("t5_old_id", 64'(rsp_id), 64'd1);
    step();
    idle_inputs();
    mem2proc_tag = 4'd4; mem2proc_data = 64'hBBBB;
    #1 check("t5_new_owner_dc", 64'(dc_rsp_valid), 64'd1);
    check("t5_new_id", 64'(rsp_id), 64'd6);
    step();
    idle_inputs();

    // Reset between allocation and return makes the tag stray.
    ic_req_valid = 1'b1; ic_req_addr = 32'h700; ic_req_id = 3'd3; mem2proc_response = 4'd2;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem2proc_tag = 4'd2; mem2proc_data = 64'hCCCC;
    #1 check("t6_stray_after_reset", 64'(stray_tag), 64'd1);
    check("t6_no_ic_rsp", 64'(ic_rsp_valid), 64'd0);
    step();
    idle_inputs();

    // Randomized traffic: clients hold requests until accepted.
    ic_pend = 0; dc_pend = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!ic_pend && ($urandom_range(1, 0) == 1)) begin
        ic_pend = 1;
        ic_req_addr = XLEN'($urandom) & ~XLEN'(7);
        ic_req_id = ID_W'($urandom);
      end
      if (!dc_pend && ($urandom_range(2, 0) != 0)) begin
        dc_pend = 1;
        dc_req_cmd = ($urandom_range(1, 0) == 1) ? BUS_LOAD : BUS_STORE;
        dc_req_addr = XLEN'($urandom);
        dc_req_data = {$urandom, $urandom};
        dc_req_size = MEM_SIZE'($urandom_range(3, 0));
        dc_req_id = ID_W'($urandom);
      end
      ic_req_valid = ic_pend;
      dc_req_valid = dc_pend;

      out_q = {};
      for (int k = 1; k < 16; k++) if (m_valid[k]) out_q.push_back(k);
      rt = 0;
      if (out_q.size() > 0 && $urandom_range(1, 0) == 1)
        rt = out_q[$urandom_range(out_q.size() - 1, 0)];
      else if ($urandom_range(19, 0) == 0)
        rt = int'($urandom_range(15, 1));
      mem2proc_tag  = 4'(rt);
      mem2proc_data = {$urandom, $urandom};

      free_q = {};
      for (int k = 1; k < 16; k++) if (!m_valid[k] || k == rt) free_q.push_back(k);
      if (free_q.size() > 0 && $urandom_range(3, 0) != 0)
        mem2proc_response = 4'(free_q[$urandom_range(free_q.size() - 1, 0)]);
      else
        mem2proc_response = 4'd0;

      reset = ($urandom_range(99, 0) == 0);
      step();
      if (last_ic_acc) ic_pend = 0;
      if (last_dc_acc) dc_pend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Processor-side initiator for the unified memory bus: arbitrates instruction-cache and data-cache requests onto the single `proc2mem_*` channel, records every accepted load by its memory tag, and routes returning `mem2proc_data` back to the owning client. Sits between the two caches and the memory model that answers `proc2mem_command` with `mem2proc_response` and `mem2proc_tag`. Replaces direct cache-to-bus wiring inside `processor`.

## Interface
- `ID_W`, 3: width of the client-side request id echoed back with returned data.
- `STARVE_LIMIT`, 8: consecutive icache-lost cycles after which icache wins arbitration.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ic_req_valid`  in  1  icache load request.
- `ic_req_addr`  in  `XLEN`  8-byte-aligned load address.
- `ic_req_id`  in  `ID_W`  icache request id.
- `ic_req_accept`  out  1  request taken by memory this cycle.
- `dc_req_valid`  in  1  dcache request.
- `dc_req_cmd`  in  2  BUS_LOAD or BUS_STORE.
- `dc_req_addr`  in  `XLEN`  address.
- `dc_req_data`  in  64  store data.
- `dc_req_size`  in  2  MEM_SIZE.
- `dc_req_id`  in  `ID_W`  dcache request id.
- `dc_req_accept`  out  1  request taken by memory this cycle.
- `ic_rsp_valid`, `dc_rsp_valid`  out  1  returned load data for that client.
- `rsp_data`  out  64  returned data (shared by both clients).
- `rsp_id`  out  `ID_W`  id of the returned request.
- `stray_tag`  out  1  returned tag matched no outstanding entry.
- `proc2mem_command`  out  2  BUS_NONE/BUS_LOAD/BUS_STORE.
- `proc2mem_addr`  out  `XLEN`; `proc2mem_data`  out  64; `proc2mem_size`  out  2.
- `mem2proc_response`  in  4  0 = refused, 1..15 = accepted with this tag.
- `mem2proc_data`  in  64; `mem2proc_tag`  in  4  0 = no return, else tag of returning load.

## Operation
- Clock is `clock`; reset is synchronous and active-high on `reset`.
- Arbitration (combinational from current requests and state): dcache wins when both valid, unless `starve_cnt == STARVE_LIMIT`, then icache wins.
- Winner drives `proc2mem_*`; icache always BUS_LOAD, size DOUBLE. No valid request: BUS_NONE, addr/data/size zero.
- Acceptance: winner's `*_req_accept` = 1 iff `mem2proc_response != 0` in the same cycle. Refused request stays unaccepted; client holds it.
- Accepted BUS_LOAD: at next edge write tag table entry `[mem2proc_response]` = {valid=1, owner, id}. Accepted BUS_STORE: no entry, no data returned.
- `starve_cnt`: increments (saturating at `STARVE_LIMIT`) when `ic_req_valid` and icache not accepted; clears when icache accepted or `ic_req_valid` = 0.
- Return: `mem2proc_tag != 0` and entry valid → same-cycle `*_rsp_valid` for owner, `rsp_data = mem2proc_data`, `rsp_id` = entry id; entry cleared at next edge. Entry invalid → `stray_tag` = 1, no rsp_valid.
- Same tag returned and reallocated in one cycle: return uses old entry; new entry written at edge (allocate wins over clear).
- Reset mid-operation: all entries invalidated, `starve_cnt` = 0; later returns of pre-reset tags raise `stray_tag`.

## Timing
- Request → accept: 0 cycles (same-cycle response). Return → rsp_valid: 0 cycles.
- Earliest return of a load accepted in cycle N: cycle N+1 (entry visible after edge).
- Reset values: all outputs 0 (`proc2mem_command` = BUS_NONE), table empty, `starve_cnt` = 0.
- At most one request and one return per cycle; both may occur together.

## Structure
- BUS_COMMAND, MEM_SIZE, `XLEN` come from the shared `sys_defs` package; add `MEM_TAG_ENTRY` struct {valid, owner, id} there.
- Sub-module `mem_tag_table`: 15-entry (tags 1..15) register file, one write port, one read/clear port, synchronous reset.

## Test plan
- Single icache load 0x100, response 3, tag 3 returns data 0xDEAD_BEEF two cycles later → `ic_req_accept` in cycle 0, `ic_rsp_valid`, `rsp_data` 0xDEADBEEF, `rsp_id` echoed.
- Both valid, dcache store 0x200 accepted (response 5) → `dc_req_accept`=1, `ic_req_accept`=0, command BUS_STORE, no entry at tag 5.
- dcache valid every cycle, icache valid: icache blocked 8 cycles, wins cycle 9 → `ic_req_accept` there, `starve_cnt` back to 0.
- Response 0 for 3 cycles then 7 → accept only in 4th cycle; outputs stable while refused.
- Tag 4 returns while new load allocated tag 4 same cycle → old owner gets data, next return of tag 4 routes to new owner.
- Load accepted tag 2, reset one cycle, tag 2 returns → `stray_tag`=1, no rsp_valid.
